// File: rtl/stream_serializer_if.sv
// Parallel-in / lane-serial-out stream bundle for stream_serializer.
// The master side presents words; the slave side serializes them.
interface stream_serializer_if #(
  parameter int PAR_WIDTH = 16,
  parameter int LANES     = 2
);
  logic [PAR_WIDTH-1:0] par_in;
  logic                 in_valid;
  logic                 in_ready;
  logic                 msb_first;
  logic [LANES-1:0]     serial_out;
  logic                 out_valid;
  logic                 frame_start;

  modport master (
    output par_in, in_valid, msb_first,
    input  in_ready, serial_out, out_valid, frame_start
  );

  modport slave (
    input  par_in, in_valid, msb_first,
    output in_ready, serial_out, out_valid, frame_start
  );
endinterface

// File: rtl/stream_serializer.sv
// Serializes PAR_WIDTH-bit words onto LANES lanes per beat, with a one-entry
// holding buffer so consecutive words stream without idle beats.
module stream_serializer #(
  parameter int   PAR_WIDTH = 16,
  parameter int   LANES     = 2,
  parameter logic IDLE_VAL  = 1'b0
) (
  input logic             clk,
  input logic             reset,
  stream_serializer_if.slave bus
);
  localparam int          BEATS = PAR_WIDTH / LANES;
  localparam int          CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned PW    = PAR_WIDTH;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  generate
    if (LANES < 1 || LANES > PAR_WIDTH || (PAR_WIDTH % LANES) != 0) begin : g_bad_params
      $fatal(1, "stream_serializer: PAR_WIDTH must be a multiple of LANES");
    end
  endgenerate

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t               state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [PAR_WIDTH-1:0] shreg, shreg_n;
  logic [PAR_WIDTH-1:0] hold, hold_n;
  logic                 hold_valid, hold_valid_n;
  logic [PAR_WIDTH-1:0] w_in, load_word;
  logic                 free, accept, load_hold, load_new, load;
  logic [LANES-1:0]     serial_n;
  logic                 out_valid_n, frame_n;

  function automatic logic [PAR_WIDTH-1:0] bit_rev(input logic [PAR_WIDTH-1:0] v);
    logic [PAR_WIDTH-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < PW; i++) r[PW-1-i] = v[i];
    return r;
  endfunction

  assign bus.in_ready = ~hold_valid & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      cnt             <= '0;
      shreg           <= '0;
      hold            <= '0;
      hold_valid      <= 1'b0;
      bus.serial_out  <= {LANES{IDLE_VAL}};
      bus.out_valid   <= 1'b0;
      bus.frame_start <= 1'b0;
    end else begin
      state           <= state_n;
      cnt             <= cnt_n;
      shreg           <= shreg_n;
      hold            <= hold_n;
      hold_valid      <= hold_valid_n;
      bus.serial_out  <= serial_n;
      bus.out_valid   <= out_valid_n;
      bus.frame_start <= frame_n;
    end
  end

  // Words are stored already in lane order, so the shifter always drains LSB-first.
  always_comb begin
    w_in         = bus.msb_first ? bit_rev(bus.par_in) : bus.par_in;
    free         = (state == IDLE) || (cnt == LAST_BEAT);
    accept       = bus.in_valid & ~hold_valid;
    load_hold    = free & hold_valid;
    load_new     = free & ~hold_valid & accept;
    load         = load_hold | load_new;
    load_word    = load_hold ? hold : w_in;
    state_n      = state;
    cnt_n        = cnt;
    shreg_n      = shreg;
    hold_n       = hold;
    hold_valid_n = hold_valid;
    if (accept && !load_new) begin
      hold_n       = w_in;
      hold_valid_n = 1'b1;
    end else if (load_hold) begin
      hold_valid_n = 1'b0;
    end
    if (load) begin
      state_n = SHIFT;
      cnt_n   = '0;
      shreg_n = load_word;
    end else if (free) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      cnt_n   = cnt + CW'(1);
      shreg_n = shreg >> LANES;
    end
  end

  always_comb begin
    out_valid_n = (state_n == SHIFT);
    frame_n     = load;
    serial_n    = out_valid_n ? shreg_n[LANES-1:0] : {LANES{IDLE_VAL}};
  end
endmodule

// File: tb/tb_stream_serializer.sv
// Directed bench for stream_serializer: default 16x2 instance plus 8x8, 8x1
// and 256x1 variants sharing one clock and reset.
module tb_stream_serializer;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  stream_serializer_if #(.PAR_WIDTH(16),  .LANES(2)) b16  ();
  stream_serializer_if #(.PAR_WIDTH(8),   .LANES(8)) b88  ();
  stream_serializer_if #(.PAR_WIDTH(8),   .LANES(1)) b81  ();
  stream_serializer_if #(.PAR_WIDTH(256), .LANES(1)) b256 ();

  stream_serializer #(.PAR_WIDTH(16),  .LANES(2), .IDLE_VAL(1'b0)) dut16  (.clk(clk), .reset(reset), .bus(b16));
  stream_serializer #(.PAR_WIDTH(8),   .LANES(8), .IDLE_VAL(1'b0)) dut88  (.clk(clk), .reset(reset), .bus(b88));
  stream_serializer #(.PAR_WIDTH(8),   .LANES(1), .IDLE_VAL(1'b0)) dut81  (.clk(clk), .reset(reset), .bus(b81));
  stream_serializer #(.PAR_WIDTH(256), .LANES(1), .IDLE_VAL(1'b0)) dut256 (.clk(clk), .reset(reset), .bus(b256));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    total++; if (b16.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", b16.out_valid); end
    total++; if (b16.frame_start !== 1'b0) begin bad++; $display("FAIL reset_frame got=%b want=0", b16.frame_start); end
    total++; if (b16.serial_out !== 2'b00) begin bad++; $display("FAIL reset_serial got=%b want=00", b16.serial_out); end
    total++; if (b16.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", b16.in_ready); end
    total++; if (b88.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid_8x8 got=%b want=0", b88.out_valid); end
    reset = 1'b0;
    #1;
    total++; if (b16.in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready got=%b want=1", b16.in_ready); end
    step();
  endtask

  task automatic run_single_word(input string name, input logic [15:0] word, input logic msb,
                                 input logic [1:0] exp [8]);
    b16.par_in    = word;
    b16.msb_first = msb;
    b16.in_valid  = 1'b1;
    step();
    b16.in_valid  = 1'b0;
    b16.par_in    = 16'h1234;
    b16.msb_first = ~msb;
    for (int k = 0; k < 8; k++) begin
      total++; if (b16.serial_out !== exp[k]) begin bad++; $display("FAIL %s_beat%0d got=%0d want=%0d", name, k, b16.serial_out, exp[k]); end
      total++; if (b16.out_valid !== 1'b1) begin bad++; $display("FAIL %s_valid%0d got=%b want=1", name, k, b16.out_valid); end
      total++; if (b16.frame_start !== (k == 0)) begin bad++; $display("FAIL %s_frame%0d got=%b want=%b", name, k, b16.frame_start, (k == 0)); end
      step();
    end
    total++; if (b16.out_valid !== 1'b0) begin bad++; $display("FAIL %s_end_valid got=%b want=0", name, b16.out_valid); end
    total++; if (b16.serial_out !== 2'b00) begin bad++; $display("FAIL %s_end_serial got=%b want=00", name, b16.serial_out); end
    step();
  endtask

  task automatic test_lsb_first();
    logic [1:0] e [8];
    e = '{2'd3, 2'd0, 2'd0, 2'd3, 2'd1, 2'd1, 2'd2, 2'd2};
    run_single_word("lsb", 16'hA5C3, 1'b0, e);
  endtask

  task automatic test_msb_first();
    logic [1:0] e [8];
    e = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd0, 2'd0, 2'd3};
    run_single_word("msb", 16'hA5C3, 1'b1, e);
  endtask

  task automatic test_back_to_back();
    logic [15:0] words [3];
    logic        acc, ev, ef, er;
    logic [1:0]  es;
    int          idx;
    words = '{16'h0001, 16'h8000, 16'hFFFF};
    idx = 0;
    b16.par_in    = words[0];
    b16.msb_first = 1'b0;
    b16.in_valid  = 1'b1;
    for (int c = 0; c < 25; c++) begin
      acc = b16.in_valid & b16.in_ready;
      step();
      if (acc) begin
        idx++;
        if (idx < 3) b16.par_in = words[idx];
        else b16.in_valid = 1'b0;
      end
      ev = (c < 24);
      ef = ev && (c % 8 == 0);
      er = (c == 0) || (c == 8) || (c >= 16);
      es = (c == 0) ? 2'd1 : (c == 15) ? 2'd2 : (c >= 16 && c < 24) ? 2'd3 : 2'd0;
      total++; if (b16.out_valid !== ev) begin bad++; $display("FAIL b2b_valid c=%0d got=%b want=%b", c, b16.out_valid, ev); end
      total++; if (b16.frame_start !== ef) begin bad++; $display("FAIL b2b_frame c=%0d got=%b want=%b", c, b16.frame_start, ef); end
      total++; if (b16.serial_out !== es) begin bad++; $display("FAIL b2b_serial c=%0d got=%0d want=%0d", c, b16.serial_out, es); end
      total++; if (b16.in_ready !== er) begin bad++; $display("FAIL b2b_ready c=%0d got=%b want=%b", c, b16.in_ready, er); end
    end
    step();
  endtask

  task automatic test_backpressure();
    logic       acc, ev;
    logic [1:0] es;
    int         idx;
    idx = 0;
    b16.par_in    = 16'h0000;
    b16.msb_first = 1'b0;
    b16.in_valid  = 1'b1;
    for (int c = 0; c < 25; c++) begin
      acc = b16.in_valid & b16.in_ready;
      step();
      if (acc) idx++;
      if (idx == 1) b16.par_in = 16'hFFFF;
      else if (idx == 2) b16.par_in = b16.in_ready ? 16'h0F0F : ((c < 4) ? 16'h1234 : 16'h5678);
      else b16.in_valid = 1'b0;
      ev = (c < 24);
      es = (c >= 8 && c < 16) ? 2'd3 : (c >= 16 && c < 24 && ((c - 16) % 4) < 2) ? 2'd3 : 2'd0;
      total++; if (b16.out_valid !== ev) begin bad++; $display("FAIL bp_valid c=%0d got=%b want=%b", c, b16.out_valid, ev); end
      total++; if (b16.serial_out !== es) begin bad++; $display("FAIL bp_serial c=%0d got=%0d want=%0d", c, b16.serial_out, es); end
    end
    step();
  endtask

  task automatic test_reset_mid_word();
    b16.par_in    = 16'hFFFF;
    b16.msb_first = 1'b0;
    b16.in_valid  = 1'b1;
    step();
    b16.par_in = 16'hAAAA;
    step();
    b16.in_valid = 1'b0;
    total++; if (b16.in_ready !== 1'b0) begin bad++; $display("FAIL rst_mid_hold_full got=%b want=0", b16.in_ready); end
    step();
    step();
    total++; if (b16.serial_out !== 2'd3) begin bad++; $display("FAIL rst_mid_beat3 got=%0d want=3", b16.serial_out); end
    reset = 1'b1;
    step();
    total++; if (b16.out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got=%b want=0", b16.out_valid); end
    total++; if (b16.serial_out !== 2'b00) begin bad++; $display("FAIL rst_mid_serial got=%b want=00", b16.serial_out); end
    total++; if (b16.in_ready !== 1'b0) begin bad++; $display("FAIL rst_mid_ready got=%b want=0", b16.in_ready); end
    reset = 1'b0;
    #1;
    total++; if (b16.in_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_ready_after got=%b want=1", b16.in_ready); end
    for (int c = 0; c < 10; c++) begin
      step();
      total++; if (b16.out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_discard c=%0d got=%b want=0", c, b16.out_valid); end
    end
    b16.par_in   = 16'h0003;
    b16.in_valid = 1'b1;
    step();
    b16.in_valid = 1'b0;
    total++; if (b16.serial_out !== 2'd3) begin bad++; $display("FAIL rst_mid_new_beat0 got=%0d want=3", b16.serial_out); end
    total++; if (b16.frame_start !== 1'b1) begin bad++; $display("FAIL rst_mid_new_frame got=%b want=1", b16.frame_start); end
    step();
    total++; if (b16.serial_out !== 2'd0) begin bad++; $display("FAIL rst_mid_new_beat1 got=%0d want=0", b16.serial_out); end
    total++; if (b16.out_valid !== 1'b1) begin bad++; $display("FAIL rst_mid_new_valid got=%b want=1", b16.out_valid); end
    for (int c = 0; c < 8; c++) step();
  endtask

  task automatic test_w8_l8();
    logic [7:0] words [4];
    logic       msbs  [4];
    logic [7:0] exps  [4];
    words = '{8'h1E, 8'h1E, 8'hC1, 8'h80};
    msbs  = '{1'b0, 1'b1, 1'b0, 1'b1};
    exps  = '{8'h1E, 8'h78, 8'hC1, 8'h01};
    for (int i = 0; i < 4; i++) begin
      b88.par_in    = words[i];
      b88.msb_first = msbs[i];
      b88.in_valid  = 1'b1;
      total++; if (b88.in_ready !== 1'b1) begin bad++; $display("FAIL w8l8_ready i=%0d got=%b want=1", i, b88.in_ready); end
      step();
      total++; if (b88.serial_out !== exps[i]) begin bad++; $display("FAIL w8l8_serial i=%0d got=%h want=%h", i, b88.serial_out, exps[i]); end
      total++; if (b88.out_valid !== 1'b1) begin bad++; $display("FAIL w8l8_valid i=%0d got=%b want=1", i, b88.out_valid); end
      total++; if (b88.frame_start !== 1'b1) begin bad++; $display("FAIL w8l8_frame i=%0d got=%b want=1", i, b88.frame_start); end
    end
    b88.in_valid = 1'b0;
    step();
    total++; if (b88.out_valid !== 1'b0) begin bad++; $display("FAIL w8l8_idle_valid got=%b want=0", b88.out_valid); end
    total++; if (b88.serial_out !== 8'h00) begin bad++; $display("FAIL w8l8_idle_serial got=%h want=00", b88.serial_out); end
  endtask

  task automatic test_w8_l1();
    logic [15:0] e;
    logic        acc, ev, ef, es;
    int          idx;
    e   = {8'h2D, 8'hB4};
    idx = 0;
    b81.par_in    = 8'hB4;
    b81.msb_first = 1'b0;
    b81.in_valid  = 1'b1;
    for (int c = 0; c < 17; c++) begin
      acc = b81.in_valid & b81.in_ready;
      step();
      if (acc) begin
        idx++;
        if (idx == 1) b81.msb_first = 1'b1;
        else b81.in_valid = 1'b0;
      end
      ev = (c < 16);
      ef = (c == 0) || (c == 8);
      es = ev ? e[c] : 1'b0;
      total++; if (b81.out_valid !== ev) begin bad++; $display("FAIL w8l1_valid c=%0d got=%b want=%b", c, b81.out_valid, ev); end
      total++; if (b81.frame_start !== ef) begin bad++; $display("FAIL w8l1_frame c=%0d got=%b want=%b", c, b81.frame_start, ef); end
      total++; if (b81.serial_out !== es) begin bad++; $display("FAIL w8l1_serial c=%0d got=%b want=%b", c, b81.serial_out, es); end
    end
  endtask

  task automatic test_w256_l1();
    logic [255:0] w;
    logic         acc, ev, ef, es;
    int           idx;
    w = {32'h01234567, 32'h89ABCDEF, 32'hDEADBEEF, 32'h0F1E2D3C,
         32'hCAFEF00D, 32'h13579BDF, 32'h2468ACE0, 32'h80000001};
    idx = 0;
    b256.par_in    = w;
    b256.msb_first = 1'b0;
    b256.in_valid  = 1'b1;
    for (int c = 0; c < 513; c++) begin
      acc = b256.in_valid & b256.in_ready;
      step();
      if (acc) begin
        idx++;
        if (idx == 1) b256.msb_first = 1'b1;
        else begin
          b256.in_valid = 1'b0;
          b256.par_in   = '0;
        end
      end
      ev = (c < 512);
      ef = (c == 0) || (c == 256);
      es = (c < 256) ? w[c] : (c < 512) ? w[511 - c] : 1'b0;
      total++; if (b256.out_valid !== ev) begin bad++; $display("FAIL w256_valid c=%0d got=%b want=%b", c, b256.out_valid, ev); end
      total++; if (b256.frame_start !== ef) begin bad++; $display("FAIL w256_frame c=%0d got=%b want=%b", c, b256.frame_start, ef); end
      total++; if (b256.serial_out !== es) begin bad++; $display("FAIL w256_serial c=%0d got=%b want=%b", c, b256.serial_out, es); end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    b16.par_in  = '0; b16.in_valid  = 1'b0; b16.msb_first  = 1'b0;
    b88.par_in  = '0; b88.in_valid  = 1'b0; b88.msb_first  = 1'b0;
    b81.par_in  = '0; b81.in_valid  = 1'b0; b81.msb_first  = 1'b0;
    b256.par_in = '0; b256.in_valid = 1'b0; b256.msb_first = 1'b0;
    test_reset();
    test_lsb_first();
    test_msb_first();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_word();
    test_w8_l8();
    test_w8_l1();
    test_w256_l1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
